// File: rtl/alu_pkg.sv
// Shared types and defaults for the handshaked multi-cycle ALU (alu_mc)
// and its iterative multiplier.
package alu_pkg;

  localparam int ALU_WIDTH = 64;

  typedef enum logic [2:0] {
    SUB = 3'b000,
    AND = 3'b001,
    XOR = 3'b010,
    OR  = 3'b011,
    SLL = 3'b100,
    SRL = 3'b101,
    MUL = 3'b110,
    ADD = 3'b111
  } aluOp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } aluState_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier retiring MUL_STEP multiplier bits per cycle;
// always runs the full WIDTH/MUL_STEP iterations so latency is fixed.
module alu_mul_iter #(
  parameter int WIDTH    = 64,
  parameter int MUL_STEP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int STEPS = WIDTH / MUL_STEP;
  localparam int CW    = $clog2(STEPS + 1);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    count;

  // Partial products of the low MUL_STEP multiplier bits, folded into acc.
  always_comb begin
    acc_next = acc;
    for (int i = 0; i < MUL_STEP; i++) begin
      if (mplier[i]) begin
        acc_next = acc_next + (mcand << i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= op_a;
      mplier <= op_b;
      count  <= CW'(STEPS);
    end else if (count != '0) begin
      acc    <= acc_next;
      mcand  <= mcand << MUL_STEP;
      mplier <= mplier >> MUL_STEP;
      count  <= count - CW'(1);
    end
  end

  assign done    = (count == '0);
  assign product = acc;

endmodule

// File: rtl/alu_mc.sv
// Handshaked ALU: single-cycle add/sub/logic/shift ops plus iterative MUL.
// Optional status flags (carry, overflow, negative) when ALU_MC_FLAGS_EN is defined.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH    = ALU_WIDTH,
  parameter int MUL_STEP = 1
) (
  input  logic             clk_in,
  input  logic             resetN_in,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic [2:0]       aluOpcode_in,
  input  logic [WIDTH-1:0] operand1_in,
  input  logic [WIDTH-1:0] operand2_in,
  output logic             valid_out,
  input  logic             ready_in,
  output logic [WIDTH-1:0] result_out,
  output logic             zeroFlag_out
`ifdef ALU_MC_FLAGS_EN
  ,
  output logic             carryFlag_out,
  output logic             overflowFlag_out,
  output logic             negFlag_out
`endif
);

  localparam int SHW = $clog2(WIDTH);

  aluState_t        state;
  aluOp_t           op;
  logic             accept;
  logic             mul_start;
  logic             mul_done;
  logic             load_alu;
  logic             load_mul;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] mul_product;

  assign op        = aluOp_t'(aluOpcode_in);
  assign ready_out = (state == IDLE) || ((state == DONE) && ready_in);
  assign accept    = valid_in && ready_out;
  assign mul_start = accept && (op == MUL);
  assign load_alu  = accept && (op != MUL);
  assign load_mul  = (state == BUSY) && mul_done;

  always_comb begin
    alu_res = '0;
    case (op)
      ADD:     alu_res = operand1_in + operand2_in;
      SUB:     alu_res = operand1_in - operand2_in;
      AND:     alu_res = operand1_in & operand2_in;
      OR:      alu_res = operand1_in | operand2_in;
      XOR:     alu_res = operand1_in ^ operand2_in;
      SLL:     alu_res = operand1_in << operand2_in[SHW-1:0];
      SRL:     alu_res = operand1_in >> operand2_in[SHW-1:0];
      default: alu_res = '0;
    endcase
  end

  alu_mul_iter #(
    .WIDTH    (WIDTH),
    .MUL_STEP (MUL_STEP)
  ) u_mul (
    .clk     (clk_in),
    .rst_n   (resetN_in),
    .start   (mul_start),
    .op_a    (operand1_in),
    .op_b    (operand2_in),
    .done    (mul_done),
    .product (mul_product)
  );

  // A consume in DONE is implied by accept there, since ready_out needs ready_in.
  always_ff @(posedge clk_in or negedge resetN_in) begin
    if (!resetN_in) begin
      state        <= IDLE;
      valid_out    <= 1'b0;
      result_out   <= '0;
      zeroFlag_out <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (mul_start) begin
            state     <= BUSY;
            valid_out <= 1'b0;
          end else if (load_alu) begin
            state        <= DONE;
            valid_out    <= 1'b1;
            result_out   <= alu_res;
            zeroFlag_out <= (alu_res == '0);
          end else if ((state == DONE) && ready_in) begin
            state     <= IDLE;
            valid_out <= 1'b0;
          end
        end
        BUSY: begin
          if (load_mul) begin
            state        <= DONE;
            valid_out    <= 1'b1;
            result_out   <= mul_product;
            zeroFlag_out <= (mul_product == '0);
          end
        end
        default: begin
          state     <= IDLE;
          valid_out <= 1'b0;
        end
      endcase
    end
  end

`ifdef ALU_MC_FLAGS_EN
  logic [WIDTH:0] sum_ext;
  logic [WIDTH:0] diff_ext;
  logic           carry_c;
  logic           ovf_c;

  // Subtraction as a + ~b + 1 so the carry-out is directly NOT borrow.
  always_comb begin
    sum_ext  = {1'b0, operand1_in} + {1'b0, operand2_in};
    diff_ext = {1'b0, operand1_in} + {1'b0, ~operand2_in} + {{WIDTH{1'b0}}, 1'b1};
    carry_c  = 1'b0;
    ovf_c    = 1'b0;
    case (op)
      ADD: begin
        carry_c = sum_ext[WIDTH];
        ovf_c   = (operand1_in[WIDTH-1] == operand2_in[WIDTH-1]) &&
                  (sum_ext[WIDTH-1] != operand1_in[WIDTH-1]);
      end
      SUB: begin
        carry_c = diff_ext[WIDTH];
        ovf_c   = (operand1_in[WIDTH-1] != operand2_in[WIDTH-1]) &&
                  (diff_ext[WIDTH-1] != operand1_in[WIDTH-1]);
      end
      default: begin
        carry_c = 1'b0;
        ovf_c   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge resetN_in) begin
    if (!resetN_in) begin
      carryFlag_out    <= 1'b0;
      overflowFlag_out <= 1'b0;
      negFlag_out      <= 1'b0;
    end else if (load_alu) begin
      carryFlag_out    <= carry_c;
      overflowFlag_out <= ovf_c;
      negFlag_out      <= alu_res[WIDTH-1];
    end else if (load_mul) begin
      carryFlag_out    <= 1'b0;
      overflowFlag_out <= 1'b0;
      negFlag_out      <= mul_product[WIDTH-1];
    end
  end
`endif

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: two instances (MUL_STEP 1 and 4) share one stimulus stream.
module tb_alu_mc;
  import alu_pkg::*;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         valid_in = 1'b0;
  logic         ready_in = 1'b0;
  logic [2:0]   opcode = 3'b000;
  logic [W-1:0] op1 = '0;
  logic [W-1:0] op2 = '0;

  logic         ready1, valid1, zero1;
  logic [W-1:0] result1;
  logic         ready4, valid4, zero4;
  logic [W-1:0] result4;
`ifdef ALU_MC_FLAGS_EN
  logic         carry1, ovf1, neg1;
  logic         carry4, ovf4, neg4;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(W), .MUL_STEP(1)) u_dut (
    .clk_in           (clk),
    .resetN_in        (rst_n),
    .valid_in         (valid_in),
    .ready_out        (ready1),
    .aluOpcode_in     (opcode),
    .operand1_in      (op1),
    .operand2_in      (op2),
    .valid_out        (valid1),
    .ready_in         (ready_in),
    .result_out       (result1),
    .zeroFlag_out     (zero1)
`ifdef ALU_MC_FLAGS_EN
    ,
    .carryFlag_out    (carry1),
    .overflowFlag_out (ovf1),
    .negFlag_out      (neg1)
`endif
  );

  alu_mc #(.WIDTH(W), .MUL_STEP(4)) u_dut4 (
    .clk_in           (clk),
    .resetN_in        (rst_n),
    .valid_in         (valid_in),
    .ready_out        (ready4),
    .aluOpcode_in     (opcode),
    .operand1_in      (op1),
    .operand2_in      (op2),
    .valid_out        (valid4),
    .ready_in         (ready_in),
    .result_out       (result4),
    .zeroFlag_out     (zero4)
`ifdef ALU_MC_FLAGS_EN
    ,
    .carryFlag_out    (carry4),
    .overflowFlag_out (ovf4),
    .negFlag_out      (neg4)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] op, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic rdy);
    valid_in = v;
    opcode   = op;
    op1      = a;
    op2      = b;
    ready_in = rdy;
  endtask

  task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                             input logic [W-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkBit(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  // Fires one MUL, then measures latency on both instances within a bounded window.
  task automatic runMul(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] expected);
    int           lat1;
    int           lat4;
    int           busy_bad;
    logic [W-1:0] res1;
    logic [W-1:0] res4;
    lat1     = 0;
    lat4     = 0;
    busy_bad = 0;
    res1     = '0;
    res4     = '0;
    applyStimulus(1'b1, MUL, a, b, 1'b1);
    tick();
    applyStimulus(1'b0, MUL, '0, '0, 1'b1);
    checkBit({tag, " ready low after accept"}, ready1, 1'b0);
    for (int cyc = 1; cyc <= 80; cyc++) begin
      tick();
      if (lat1 == 0) begin
        if (valid1) begin
          lat1 = cyc;
          res1 = result1;
        end else if (ready1 !== 1'b0) begin
          busy_bad++;
        end
      end
      if ((lat4 == 0) && valid4) begin
        lat4 = cyc;
        res4 = result4;
      end
    end
    checkOutput({tag, " latency step1"}, 64'(lat1), 64'd65);
    checkOutput({tag, " latency step4"}, 64'(lat4), 64'd17);
    checkOutput({tag, " result step1"}, res1, expected);
    checkOutput({tag, " result step4"}, res4, expected);
    checkOutput({tag, " ready high while busy"}, 64'(busy_bad), 64'd0);
  endtask

  task automatic resetMidBusy();
    int late;
    late = 0;
    applyStimulus(1'b1, MUL, 64'd3, 64'd4, 1'b1);
    tick();
    applyStimulus(1'b0, MUL, '0, '0, 1'b1);
    repeat (5) tick();
    checkBit("rst busy before reset", ready1, 1'b0);
    rst_n = 1'b0;
    #1;
    checkBit("rst valid step1", valid1, 1'b0);
    checkBit("rst valid step4", valid4, 1'b0);
    checkBit("rst ready", ready1, 1'b1);
    checkOutput("rst result", result1, '0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 80; cyc++) begin
      tick();
      if (valid1 || valid4) late++;
    end
    checkOutput("rst no stale result", 64'(late), 64'd0);
    checkBit("rst ready after release", ready1, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, ADD, '0, '0, 1'b0);
    tick();
    tick();
    checkBit("reset valid", valid1, 1'b0);
    checkBit("reset ready", ready1, 1'b1);
    checkBit("reset zero", zero1, 1'b0);
    checkOutput("reset result", result1, '0);
    rst_n = 1'b1;
    tick();

    // ADD wraps to zero
    applyStimulus(1'b1, ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
    tick();
    checkBit("add valid", valid1, 1'b1);
    checkOutput("add result", result1, '0);
    checkBit("add zero", zero1, 1'b1);
`ifdef ALU_MC_FLAGS_EN
    checkBit("add carry", carry1, 1'b1);
    checkBit("add overflow", ovf1, 1'b0);
    checkBit("add neg", neg1, 1'b0);
`endif
    applyStimulus(1'b0, ADD, '0, '0, 1'b1);
    tick();
    checkBit("add consumed", valid1, 1'b0);

    applyStimulus(1'b1, SUB, 64'd5, 64'd5, 1'b1);
    tick();
    checkOutput("sub result", result1, '0);
    checkBit("sub zero", zero1, 1'b1);
`ifdef ALU_MC_FLAGS_EN
    checkBit("sub carry", carry1, 1'b1);
`endif
    applyStimulus(1'b1, SLL, 64'd1, 64'd67, 1'b1);
    tick();
    checkOutput("sll result", result1, 64'd8);
    checkBit("sll zero", zero1, 1'b0);
    applyStimulus(1'b1, SRL, 64'h8000_0000_0000_0080, 64'd4, 1'b1);
    tick();
    checkOutput("srl result", result1, 64'h0800_0000_0000_0008);
    applyStimulus(1'b0, ADD, '0, '0, 1'b1);
    tick();

    runMul("mul", 64'd12345, 64'd678, 64'd8369910);
    runMul("mul zero", 64'd0, 64'd99, 64'd0);

    // Backpressure: result must hold while new requests are ignored
    applyStimulus(1'b1, AND, 64'hF0, 64'h3C, 1'b0);
    tick();
    checkBit("bp valid", valid1, 1'b1);
    checkOutput("bp result", result1, 64'h30);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, XOR, 64'h1234, 64'h5678, 1'b0);
      tick();
      checkOutput("bp hold result", result1, 64'h30);
      checkBit("bp hold valid", valid1, 1'b1);
      checkBit("bp ready low", ready1, 1'b0);
    end
    applyStimulus(1'b0, AND, '0, '0, 1'b1);
    #1;
    checkBit("bp ready follows ready_in", ready1, 1'b1);
    tick();
    checkBit("bp consumed", valid1, 1'b0);

    // Back-to-back stream
    applyStimulus(1'b1, OR, 64'h0F00, 64'h00F0, 1'b1);
    tick();
    checkOutput("b2b or", result1, 64'h0FF0);
    checkBit("b2b ready", ready1, 1'b1);
    applyStimulus(1'b1, XOR, 64'hFF, 64'h0F, 1'b1);
    tick();
    checkOutput("b2b xor", result1, 64'hF0);
    checkBit("b2b valid", valid1, 1'b1);
    applyStimulus(1'b1, ADD, 64'h100, 64'h23, 1'b1);
    tick();
    checkOutput("b2b add", result1, 64'h123);
    applyStimulus(1'b0, ADD, '0, '0, 1'b1);
    tick();
    checkBit("b2b drained", valid1, 1'b0);

    resetMidBusy();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
